// File: rtl/puf_uart_pkg.sv
// Shared UART definitions for the PUF host link (receiver and transmitter).
package puf_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 byte receiver: 2-FF rx synchroniser, mid-bit sampling FSM, framing-error detect.
module uart_rx_core
  import puf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_rx,
  output logic [UART_DATA_BITS-1:0] o_byte,
  output logic                      o_byte_valid,
  output logic                      o_frame_err,
  output rx_state_t                 o_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

  logic                      r_rx_meta;
  logic                      r_rx_s;
  rx_state_t                 r_state;
  logic [CW-1:0]             r_bit_clk;
  logic [IW-1:0]             r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_frame_err;

  rx_state_t                 w_state_nx;
  logic [CW-1:0]             w_bit_clk_nx;
  logic [IW-1:0]             w_bit_idx_nx;
  logic [UART_DATA_BITS-1:0] w_data_nx;
  logic                      w_accept;
  logic                      w_ferr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= IDLE;
      r_bit_clk   <= '0;
      r_bit_idx   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= i_rx;
      r_rx_s      <= r_rx_meta;
      r_state     <= w_state_nx;
      r_bit_clk   <= w_bit_clk_nx;
      r_bit_idx   <= w_bit_idx_nx;
      r_frame_err <= w_ferr;
    end
  end

  always_ff @(posedge clk) begin
    r_data <= w_data_nx;
  end

  // Samples are taken mid-bit: START waits half a bit, later states a full bit.
  always_comb begin
    w_state_nx   = r_state;
    w_bit_clk_nx = r_bit_clk + CW'(1);
    w_bit_idx_nx = r_bit_idx;
    w_data_nx    = r_data;
    w_accept     = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      IDLE: begin
        w_bit_clk_nx = '0;
        if (!r_rx_s) w_state_nx = START;
      end
      START: begin
        if (r_bit_clk == HALF_BIT) begin
          w_bit_clk_nx = '0;
          w_bit_idx_nx = '0;
          w_state_nx   = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_bit_clk == FULL_BIT) begin
          w_bit_clk_nx         = '0;
          w_data_nx[r_bit_idx] = r_rx_s;
          if (r_bit_idx == LAST_BIT) w_state_nx = STOP;
          else w_bit_idx_nx = r_bit_idx + IW'(1);
        end
      end
      STOP: begin
        if (r_bit_clk == FULL_BIT) begin
          w_bit_clk_nx = '0;
          if (r_rx_s) begin
            w_accept   = 1'b1;
            w_state_nx = IDLE;
          end else begin
            w_ferr     = 1'b1;
            w_state_nx = BREAK;
          end
        end
      end
      BREAK: begin
        w_bit_clk_nx = '0;
        if (r_rx_s) w_state_nx = IDLE;
      end
      default: begin
        w_bit_clk_nx = '0;
        w_state_nx   = IDLE;
      end
    endcase
  end

  assign o_byte       = r_data;
  assign o_byte_valid = w_accept;
  assign o_frame_err  = r_frame_err;
  assign o_state      = r_state;

endmodule

// File: rtl/uart_challenge_rx.sv
// Assembles N/8 UART bytes (MSB byte first) into an N-bit arbiter challenge with
// a one-cycle valid pulse; partial challenges are dropped on framing error or idle timeout.
module uart_challenge_rx
  import puf_uart_pkg::*;
#(
  parameter int N            = 128,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [N-1:0]           challenge,
  output logic                   challenge_valid,
  output logic                   frame_err,
  output logic [$clog2(N/8)-1:0] byte_cnt,
  output logic                   busy
);

  localparam int NB = N / UART_DATA_BITS;
  localparam int BW = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

  logic [UART_DATA_BITS-1:0] w_byte;
  logic                      w_byte_valid;
  logic                      w_frame_err;
  rx_state_t                 w_state;
  logic [N-1:0]              w_shift_nx;
  logic                      w_timeout;
  logic                      w_idle_count;

  logic [N-1:0]  r_shift;
  logic [N-1:0]  r_challenge;
  logic          r_valid;
  logic [BW-1:0] r_byte_cnt;
  logic [TW-1:0] r_idle_clk;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (rx),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err),
    .o_state     (w_state)
  );

  assign w_shift_nx   = {r_shift[N-UART_DATA_BITS-1:0], w_byte};
  assign w_idle_count = (w_state == IDLE) && (r_byte_cnt != '0);
  assign w_timeout    = w_idle_count && (r_idle_clk == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (w_byte_valid) r_shift <= w_shift_nx;
  end

  // Accept happens only in STOP and timeout only in IDLE, so the branches never collide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_challenge <= '0;
      r_valid     <= 1'b0;
      r_byte_cnt  <= '0;
      r_idle_clk  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_byte_valid) begin
        if (r_byte_cnt == LAST_BYTE) begin
          r_challenge <= w_shift_nx;
          r_valid     <= 1'b1;
          r_byte_cnt  <= '0;
        end else begin
          r_byte_cnt <= r_byte_cnt + BW'(1);
        end
      end else if (w_frame_err || w_timeout) begin
        r_byte_cnt <= '0;
      end
      r_idle_clk <= (w_idle_count && !w_timeout) ? r_idle_clk + TW'(1) : '0;
    end
  end

  assign challenge       = r_challenge;
  assign challenge_valid = r_valid;
  assign frame_err       = w_frame_err;
  assign byte_cnt        = r_byte_cnt;
  assign busy            = (w_state != IDLE) || (r_byte_cnt != '0);

endmodule

// File: tb/tb_uart_challenge_rx.sv
// Scoreboard bench for uart_challenge_rx: serial frames in, challenge words checked on valid.
module tb_uart_challenge_rx;

  localparam int N    = 128;
  localparam int CPB  = 8;
  localparam int TOUT = 200;

  logic         clk;
  logic         reset;
  logic         rx;
  logic [N-1:0] challenge;
  logic         challenge_valid;
  logic         frame_err;
  logic [3:0]   byte_cnt;
  logic         busy;

  uart_challenge_rx #(
    .N           (N),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx),
    .challenge      (challenge),
    .challenge_valid(challenge_valid),
    .frame_err      (frame_err),
    .byte_cnt       (byte_cnt),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_valid = 0;
  int           n_ferr = 0;
  logic         prev_valid = 1'b0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_chal = '0;

  // One clock: sample outputs on the falling edge and settle any valid pulse against the scoreboard.
  task automatic tick();
    logic [N-1:0] exp_v;
    @(negedge clk);
    if (challenge_valid) begin
      n_valid++;
      n_cmp++;
      if (prev_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_width: challenge_valid high for consecutive cycles, required single-cycle pulse");
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got challenge %h, required no pulse", challenge);
      end else begin
        exp_v = exp_q.pop_front();
        if (challenge !== exp_v) begin
          n_fail++;
          $display("FAIL challenge: got %h, required %h", challenge, exp_v);
        end
      end
    end
    if (frame_err) n_ferr++;
    prev_valid = challenge_valid;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int idle_bits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    for (int i = 0; i < idle_bits; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [N-1:0] v, input int idle_bits);
    exp_q.push_back(v);
    last_chal = v;
    for (int i = N / 8 - 1; i >= 0; i--) send_byte(v[i*8+:8], 1'b1, idle_bits);
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d challenges never published, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (byte_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_byte_cnt: got %0d, required 0", name, byte_cnt);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_cmp++;
    if (challenge !== '0) begin
      n_fail++; $display("FAIL %s_challenge: got %h, required 0", name, challenge);
    end
    n_cmp++;
    if (challenge_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_valid: got %b, required 0", name, challenge_valid);
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL %s_frame_err: got %b, required 0", name, frame_err);
    end
    n_cmp++;
    if (byte_cnt !== 4'd0) begin
      n_fail++; $display("FAIL %s_byte_cnt: got %0d, required 0", name, byte_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy: got %b, required 0", name, busy);
    end
  endtask

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32+:32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) tick();
    check_zero_outputs("reset");
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_known_frame();
    logic [7:0] bytes[16] = '{8'h9a, 8'hcb, 8'he9, 8'h41, 8'ha5, 8'hb8, 8'h20, 8'h2e,
                              8'hf4, 8'hed, 8'h6b, 8'ha0, 8'h7a, 8'h95, 8'h1d, 8'h19};
    logic [N-1:0] v = '0;
    int v0;
    for (int i = 0; i < 16; i++) v = {v[N-9:0], bytes[i]};
    n_cmp++;
    if (v !== 128'h9acbe941a5b8202ef4ed6ba07a951d19) begin
      n_fail++; $display("FAIL known_vector: assembled %h, required 9acbe941a5b8202ef4ed6ba07a951d19", v);
    end
    v0 = n_valid;
    send_frame(v, 1);
    repeat (20) tick();
    check_drained("known");
    n_cmp++;
    if (n_valid - v0 != 1) begin
      n_fail++; $display("FAIL known_pulses: got %0d valid pulses, required 1", n_valid - v0);
    end
  endtask

  task automatic test_glitch();
    int f0 = n_ferr;
    int v0 = n_valid;
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    n_cmp++;
    if (byte_cnt !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL glitch_idle: byte_cnt %0d busy %b, required 0 and 0", byte_cnt, busy);
    end
    n_cmp++;
    if (n_ferr != f0 || n_valid != v0) begin
      n_fail++; $display("FAIL glitch_pulses: frame_err %0d valid %0d, required 0 and 0", n_ferr - f0, n_valid - v0);
    end
  endtask

  task automatic test_frame_error();
    int f0 = n_ferr;
    int v0 = n_valid;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1);
    n_cmp++;
    if (byte_cnt !== 4'd4) begin
      n_fail++; $display("FAIL ferr_partial: byte_cnt %0d, required 4", byte_cnt);
    end
    send_byte(8'h55, 1'b0, 0);
    rx = 1'b1;
    repeat (3 * CPB) tick();
    n_cmp++;
    if (n_ferr - f0 != 1) begin
      n_fail++; $display("FAIL ferr_count: got %0d frame_err pulses, required 1", n_ferr - f0);
    end
    n_cmp++;
    if (byte_cnt !== 4'd0 || n_valid != v0) begin
      n_fail++; $display("FAIL ferr_discard: byte_cnt %0d valid %0d, required 0 and 0", byte_cnt, n_valid - v0);
    end
    n_cmp++;
    if (challenge !== last_chal) begin
      n_fail++; $display("FAIL ferr_hold: challenge %h, required %h", challenge, last_chal);
    end
    send_frame(rand_frame(), 1);
    repeat (20) tick();
    check_drained("after_ferr");
  endtask

  task automatic test_timeout();
    int v0 = n_valid;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1);
    n_cmp++;
    if (byte_cnt !== 4'd3) begin
      n_fail++; $display("FAIL timeout_partial: byte_cnt %0d, required 3", byte_cnt);
    end
    rx = 1'b1;
    repeat (TOUT) tick();
    n_cmp++;
    if (byte_cnt !== 4'd0 || n_valid != v0) begin
      n_fail++; $display("FAIL timeout_clear: byte_cnt %0d valid %0d, required 0 and 0", byte_cnt, n_valid - v0);
    end
    n_cmp++;
    if (challenge !== last_chal) begin
      n_fail++; $display("FAIL timeout_hold: challenge %h, required %h", challenge, last_chal);
    end
    send_frame({N{1'b1}}, 1);
    repeat (20) tick();
    check_drained("all_ones");
  endtask

  task automatic test_break();
    int f0 = n_ferr;
    rx = 1'b0;
    repeat (40 * CPB) tick();
    n_cmp++;
    if (n_ferr - f0 != 1) begin
      n_fail++; $display("FAIL break_count: got %0d frame_err pulses, required 1", n_ferr - f0);
    end
    n_cmp++;
    if (busy !== 1'b1 || byte_cnt !== 4'd0) begin
      n_fail++; $display("FAIL break_hold: busy %b byte_cnt %0d, required 1 and 0", busy, byte_cnt);
    end
    rx = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL break_release: busy %b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'($urandom);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1, 1);
    n_cmp++;
    if (byte_cnt !== 4'd6) begin
      n_fail++; $display("FAIL midrst_partial: byte_cnt %0d, required 6", byte_cnt);
    end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_zero_outputs("midrst");
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2 * CPB) tick();
    send_frame(rand_frame(), 1);
    repeat (20) tick();
    check_drained("after_rst");
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    send_frame(rand_frame(), 0);
    send_frame(rand_frame(), 0);
    rx = 1'b1;
    repeat (20) tick();
    check_drained("b2b");
    n_cmp++;
    if (n_valid - v0 != 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d valid pulses, required 2", n_valid - v0);
    end
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_known_frame();
    test_glitch();
    test_frame_error();
    test_timeout();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
